// File: rtl/bubble_sort_engine.sv
// In-place bubble sorter over a DEPTH x WIDTH register array with a write port,
// a combinational read port, start/busy/done handshake and swap statistics.
module bubble_sort_engine #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH*(DEPTH-1)/2+1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              start,
    input  logic              descending,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  swap_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMPARE  = 2'd1,
        PASS_END = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t            state_r;
    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic [ADDR_W-1:0] idx_r;
    logic [ADDR_W-1:0] last_r;
    logic              swapped_r;
    logic              dir_r;
    logic              busy_r;
    logic              done_r;
    logic [CNT_W-1:0]  swap_count_r;

    logic [ADDR_W-1:0] idx_nxt_s;
    logic [WIDTH-1:0]  lo_val_s;
    logic [WIDTH-1:0]  hi_val_s;
    logic              out_of_order_s;

    assign busy       = busy_r;
    assign done       = done_r;
    assign swap_count = swap_count_r;

    // Current pair and its order test; equal values never count as out of order.
    always_comb begin
        idx_nxt_s = idx_r + ADDR_W'(1);
        lo_val_s  = mem_r[idx_r];
        hi_val_s  = mem_r[idx_nxt_s];
        if (dir_r) begin
            out_of_order_s = (lo_val_s < hi_val_s);
        end else begin
            out_of_order_s = (lo_val_s > hi_val_s);
        end
    end

    // Read port shows live contents, including mid-sort values.
    always_comb begin
        rd_data = {WIDTH{1'b0}};
        if (int'(rd_addr) < DEPTH) begin
            rd_data = mem_r[rd_addr];
        end else begin
            rd_data = {WIDTH{1'b0}};
        end
    end

    // Sort FSM, storage array and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            idx_r        <= ADDR_W'(0);
            last_r       <= ADDR_W'(DEPTH-1);
            swapped_r    <= 1'b0;
            dir_r        <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            swap_count_r <= CNT_W'(0);
            for (int k = 0; k < DEPTH; k++) begin
                mem_r[k] <= {WIDTH{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (wr_en && (int'(wr_addr) < DEPTH)) begin
                        mem_r[wr_addr] <= wr_data;
                    end
                    if (start) begin
                        idx_r        <= ADDR_W'(0);
                        last_r       <= ADDR_W'(DEPTH-1);
                        swapped_r    <= 1'b0;
                        swap_count_r <= CNT_W'(0);
                        dir_r        <= descending;
                        busy_r       <= 1'b1;
                        state_r      <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (out_of_order_s) begin
                        mem_r[idx_r]     <= hi_val_s;
                        mem_r[idx_nxt_s] <= lo_val_s;
                        swapped_r        <= 1'b1;
                        swap_count_r     <= swap_count_r + CNT_W'(1);
                    end
                    if (idx_r == last_r - ADDR_W'(1)) begin
                        state_r <= PASS_END;
                    end else begin
                        idx_r <= idx_nxt_s;
                    end
                end
                PASS_END: begin
                    // A clean pass means the rest is already ordered.
                    if (!swapped_r || (last_r == ADDR_W'(1))) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        last_r    <= last_r - ADDR_W'(1);
                        idx_r     <= ADDR_W'(0);
                        swapped_r <= 1'b0;
                        state_r   <= COMPARE;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Directed testbench for bubble_sort_engine (DEPTH=4, WIDTH=4) with
// hand-computed expectations for contents, latency and swap counts.
module tb_bubble_sort_engine;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       start;
    logic       descending;
    logic [1:0] rd_addr;
    logic [3:0] rd_data;
    logic       busy;
    logic       done;
    logic [2:0] swap_count;

    int checks;
    int errors;

    bubble_sort_engine #(.WIDTH(4), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .descending (descending),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .swap_count (swap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        logic [3:0] v [4];
        v = '{a, b, c, d};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = 2'(k);
            wr_data = v[k];
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Starts a sort and watches 20 cycles; cycle 1 is the first after the start edge.
    task automatic run_sort(input logic desc, output int done_cyc,
                            output int busy_cyc, output int pulses);
        @(negedge clk);
        start      = 1'b1;
        descending = desc;
        @(negedge clk);
        start    = 1'b0;
        done_cyc = -1;
        busy_cyc = 0;
        pulses   = 0;
        for (int c = 1; c <= 20; c++) begin
            if (busy) busy_cyc++;
            if (done) begin
                pulses++;
                if (done_cyc < 0) done_cyc = c;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        load4(4'd9, 4'd3, 4'd7, 4'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rd_addr = 2'(k);
            #1;
            checks++;
            if (rd_data !== 4'd0) begin
                errors++;
                $display("FAIL reset_mem[%0d]: got %0d expected 0", k, rd_data);
            end
        end
        checks++;
        if ({busy, done, swap_count} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b swap_count=%0d expected all 0",
                     busy, done, swap_count);
        end
    endtask

    task automatic test_reverse_ascending;
        logic [3:0] exp [4];
        int dc, bc, pc;
        exp = '{4'd1, 4'd2, 4'd3, 4'd4};
        load4(4'd4, 4'd3, 4'd2, 4'd1);
        run_sort(1'b0, dc, bc, pc);
        checks++;
        if (dc !== 10) begin
            errors++;
            $display("FAIL reverse_done_cycle: got %0d expected 10", dc);
        end
        checks++;
        if (bc !== 9) begin
            errors++;
            $display("FAIL reverse_busy_cycles: got %0d expected 9", bc);
        end
        checks++;
        if (pc !== 1) begin
            errors++;
            $display("FAIL reverse_done_pulses: got %0d expected 1", pc);
        end
        checks++;
        if (swap_count !== 3'd6) begin
            errors++;
            $display("FAIL reverse_swap_count: got %0d expected 6", swap_count);
        end
        for (int k = 0; k < 4; k++) begin
            rd_addr = 2'(k);
            #1;
            checks++;
            if (rd_data !== exp[k]) begin
                errors++;
                $display("FAIL reverse_mem[%0d]: got %0d expected %0d", k, rd_data, exp[k]);
            end
        end
    endtask

    task automatic test_early_exit;
        logic [3:0] exp [4];
        int dc, bc, pc;
        exp = '{4'd1, 4'd2, 4'd3, 4'd4};
        load4(4'd1, 4'd2, 4'd3, 4'd4);
        run_sort(1'b0, dc, bc, pc);
        checks++;
        if (dc !== 5) begin
            errors++;
            $display("FAIL early_done_cycle: got %0d expected 5", dc);
        end
        checks++;
        if (bc !== 4) begin
            errors++;
            $display("FAIL early_busy_cycles: got %0d expected 4", bc);
        end
        checks++;
        if (swap_count !== 3'd0) begin
            errors++;
            $display("FAIL early_swap_count: got %0d expected 0", swap_count);
        end
        for (int k = 0; k < 4; k++) begin
            rd_addr = 2'(k);
            #1;
            checks++;
            if (rd_data !== exp[k]) begin
                errors++;
                $display("FAIL early_mem[%0d]: got %0d expected %0d", k, rd_data, exp[k]);
            end
        end
    endtask

    task automatic test_descending_dups;
        logic [3:0] exp [4];
        int dc, bc, pc;
        exp = '{4'd9, 4'd5, 4'd5, 4'd0};
        load4(4'd5, 4'd9, 4'd5, 4'd0);
        run_sort(1'b1, dc, bc, pc);
        checks++;
        if (dc !== 8) begin
            errors++;
            $display("FAIL desc_done_cycle: got %0d expected 8", dc);
        end
        checks++;
        if (swap_count !== 3'd1) begin
            errors++;
            $display("FAIL desc_swap_count: got %0d expected 1", swap_count);
        end
        for (int k = 0; k < 4; k++) begin
            rd_addr = 2'(k);
            #1;
            checks++;
            if (rd_data !== exp[k]) begin
                errors++;
                $display("FAIL desc_mem[%0d]: got %0d expected %0d", k, rd_data, exp[k]);
            end
        end
    endtask

    task automatic test_busy_protection;
        logic [3:0] exp [4];
        int pc;
        exp = '{4'd2, 4'd4, 4'd6, 4'd8};
        load4(4'd8, 4'd2, 4'd6, 4'd4);
        @(negedge clk);
        start      = 1'b1;
        descending = 1'b0;
        @(negedge clk);
        start = 1'b0;
        pc    = 0;
        for (int c = 1; c <= 20; c++) begin
            if (done) pc++;
            if (c == 2) begin
                wr_en   = 1'b1;
                wr_addr = 2'd0;
                wr_data = 4'd15;
                start   = 1'b1;
            end else begin
                wr_en = 1'b0;
                start = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (pc !== 1) begin
            errors++;
            $display("FAIL protect_done_pulses: got %0d expected 1", pc);
        end
        checks++;
        if (swap_count !== 3'd4) begin
            errors++;
            $display("FAIL protect_swap_count: got %0d expected 4", swap_count);
        end
        for (int k = 0; k < 4; k++) begin
            rd_addr = 2'(k);
            #1;
            checks++;
            if (rd_data !== exp[k]) begin
                errors++;
                $display("FAIL protect_mem[%0d]: got %0d expected %0d", k, rd_data, exp[k]);
            end
        end
    endtask

    task automatic test_reset_mid_sort;
        logic [3:0] exp [4];
        int dc, bc, pc;
        exp = '{4'd0, 4'd1, 4'd2, 4'd3};
        load4(4'd4, 4'd3, 4'd2, 4'd1);
        @(negedge clk);
        start      = 1'b1;
        descending = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, swap_count} !== 5'b0) begin
            errors++;
            $display("FAIL midrst_outputs: busy=%b done=%b swap_count=%0d expected all 0",
                     busy, done, swap_count);
        end
        for (int k = 0; k < 4; k++) begin
            rd_addr = 2'(k);
            #1;
            checks++;
            if (rd_data !== 4'd0) begin
                errors++;
                $display("FAIL midrst_mem[%0d]: got %0d expected 0", k, rd_data);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        pc = 0;
        for (int c = 0; c < 12; c++) begin
            if (done || busy) pc++;
            @(negedge clk);
        end
        checks++;
        if (pc !== 0) begin
            errors++;
            $display("FAIL midrst_activity: got %0d busy/done cycles expected 0", pc);
        end
        load4(4'd2, 4'd1, 4'd0, 4'd3);
        run_sort(1'b0, dc, bc, pc);
        checks++;
        if (swap_count !== 3'd3) begin
            errors++;
            $display("FAIL midrst_swap_count: got %0d expected 3", swap_count);
        end
        checks++;
        if (pc !== 1) begin
            errors++;
            $display("FAIL midrst_done_pulses: got %0d expected 1", pc);
        end
        for (int k = 0; k < 4; k++) begin
            rd_addr = 2'(k);
            #1;
            checks++;
            if (rd_data !== exp[k]) begin
                errors++;
                $display("FAIL midrst_resort_mem[%0d]: got %0d expected %0d", k, rd_data, exp[k]);
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = 2'd0;
        wr_data    = 4'd0;
        start      = 1'b0;
        descending = 1'b0;
        rd_addr    = 2'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_reverse_ascending();
        test_early_exit();
        test_descending_dups();
        test_busy_protection();
        test_reset_mid_sort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
